fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the `memory` block's read port. It keeps the program counter, issues word-aligned 4-word burst reads (or single-word reads near the top of memory), and buffers returned words in a 4-entry queue. It presents them to decode with a valid/ready handshake. Branch/jump redirects flush the queue and squash any in-flight burst.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_if.sv | 35 +++
 rtl/insn_queue.sv | 70 +++++++
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and users of the
// memory read port.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RECV,
        ST_FAULT
    } fetch_state_e;

    localparam logic [1:0] ACCESS_WORD   = 2'd0;
    localparam logic [1:0] ACCESS_BURST4 = 2'd1;
    localparam logic       MEM_READ      = 1'b1;
    localparam logic       MEM_WRITE     = 1'b0;

    localparam int QUEUE_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

    function automatic logic [2:0] access_words(input logic [1:0] size);
        return (size == ACCESS_BURST4) ? 3'd4 : 3'd1;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Memory read port, decode handshake and redirect/fault signals of the fetch
// stage. The fetch unit is the master; memory/decode/branch logic is the slave.
interface fetch_if;
    logic        mem_enable;
    logic        mem_rd_wr;
    logic [31:0] mem_addr;
    logic [1:0]  mem_access_size;
    logic        mem_busy;
    logic [31:0] mem_data_out;

    logic        redirect;
    logic [31:0] redirect_pc;

    logic        insn_valid;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        insn_ready;
    logic        fetch_fault;

    modport master (
        output mem_enable, mem_rd_wr, mem_addr, mem_access_size,
        input  mem_busy, mem_data_out,
        input  redirect, redirect_pc,
        output insn_valid, insn, insn_pc, fetch_fault,
        input  insn_ready
    );

    modport slave (
        input  mem_enable, mem_rd_wr, mem_addr, mem_access_size,
        output mem_busy, mem_data_out,
        output redirect, redirect_pc,
        input  insn_valid, insn, insn_pc, fetch_fault,
        output insn_ready
    );
endinterface

// File: rtl/insn_queue.sv
// Small FIFO of fetched {pc, insn} entries; flush is synchronous and overrides
// push and pop in the same cycle.
module insn_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(QUEUE_DEPTH));
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign head_o  = mem_q[rd_ptr_q];

    // NOTE: every variable written here gets a default first, otherwise paths
    // that skip an assignment would infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; occupancy is tracked
    // by the pointers/count, and the head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps the PC, issues word-aligned burst/single reads,
// buffers returned words and hands them to decode; redirects flush everything.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 1048576
) (
    input  logic     clk,
    input  logic     reset,
    fetch_if.master  bus
);

    localparam logic [31:0] MEM_LIMIT   = MEM_BYTES[31:0];
    localparam logic [31:0] BURST_LIMIT = MEM_LIMIT - 32'd16;

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [2:0]   words_left_q, words_left_d;
    logic         squash_q, squash_d;
    logic         mem_enable_q, mem_enable_d;
    logic [31:0]  mem_addr_q, mem_addr_d;
    logic [1:0]   mem_size_q, mem_size_d;
    logic         fault_q, fault_d;

    logic         accepted;
    logic         pc_bad;
    logic         insn_valid;
    logic         q_push, q_pop, q_empty, q_full;
    fetch_entry_t q_push_data, q_head;

    assign accepted   = mem_enable_q && !bus.mem_busy;
    assign pc_bad     = (fetch_pc_q[1:0] != 2'b00) || (fetch_pc_q >= MEM_LIMIT);
    assign insn_valid = !q_empty && (state_q != ST_FAULT);
    assign q_pop      = insn_valid && bus.insn_ready && !bus.redirect;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        words_left_d = words_left_q;
        squash_d     = squash_q;
        mem_enable_d = mem_enable_q;
        mem_addr_d   = mem_addr_q;
        mem_size_d   = mem_size_q;
        fault_d      = fault_q;
        q_push       = 1'b0;
        q_push_data  = '{pc: fetch_pc_q, insn: bus.mem_data_out};

        unique case (state_q)
            ST_IDLE: begin
                if (bus.redirect) begin
                    state_d = ST_IDLE;
                end else if (pc_bad) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else if (q_empty) begin
                    state_d      = ST_REQ;
                    mem_enable_d = 1'b1;
                    mem_addr_d   = fetch_pc_q;
                    mem_size_d   = (fetch_pc_q <= BURST_LIMIT) ? ACCESS_BURST4 : ACCESS_WORD;
                end
            end
            ST_REQ: begin
                // A request accepted in the same cycle as a redirect still
                // returns data, so it drains as a squashed burst.
                if (accepted) begin
                    state_d      = ST_RECV;
                    mem_enable_d = 1'b0;
                    words_left_d = access_words(mem_size_q);
                    squash_d     = bus.redirect;
                end else if (bus.redirect) begin
                    state_d      = ST_IDLE;
                    mem_enable_d = 1'b0;
                end
            end
            ST_RECV: begin
                q_push       = !squash_q && !bus.redirect && !q_full;
                words_left_d = words_left_q - 3'd1;
                if (!squash_q) fetch_pc_d = fetch_pc_q + 32'd4;
                if (words_left_q == 3'd1) begin
                    state_d  = ST_IDLE;
                    squash_d = 1'b0;
                end else if (bus.redirect) begin
                    squash_d = 1'b1;
                end
            end
            ST_FAULT: begin
                if (bus.redirect) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
            fault_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            fetch_pc_q   <= RESET_PC;
            words_left_q <= '0;
            squash_q     <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_addr_q   <= RESET_PC;
            mem_size_q   <= ACCESS_WORD;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            words_left_q <= words_left_d;
            squash_q     <= squash_d;
            mem_enable_q <= mem_enable_d;
            mem_addr_q   <= mem_addr_d;
            mem_size_q   <= mem_size_d;
            fault_q      <= fault_d;
        end
    end

    insn_queue u_queue (
        .clk        (clk),
        .reset      (reset),
        .push_i     (q_push),
        .push_data_i(q_push_data),
        .pop_i      (q_pop),
        .flush_i    (bus.redirect),
        .head_o     (q_head),
        .empty_o    (q_empty),
        .full_o     (q_full)
    );

    assign bus.mem_enable      = mem_enable_q;
    assign bus.mem_rd_wr       = MEM_READ;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_access_size = mem_size_q;
    assign bus.insn_valid      = insn_valid;
    assign bus.insn            = insn_valid ? q_head.insn : 32'd0;
    assign bus.insn_pc         = insn_valid ? q_head.pc : 32'd0;
    assign bus.fetch_fault     = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a
// randomized phase checked against a transaction-level program-order model.
`timescale 1ns/1ps
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned MEM_BYTES = 1048576;

    logic clk = 1'b0;
    logic reset;
    fetch_if bus ();

    fetch_unit #(.RESET_PC(RESET_PC), .MEM_BYTES(MEM_BYTES)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int xfers    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Contents of the memory: the first four words are fixed, the rest hashed.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd0:   return 32'd234;
            32'd4:   return 32'd1537628013;
            32'd8:   return 32'd537628013;
            32'd12:  return 32'd2537628013;
            default: return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
        endcase
    endfunction

    function automatic logic [31:0] pick_pc();
        int r;
        r = $urandom_range(0, 15);
        if (r <= 10) return 32'($urandom_range(0, MEM_BYTES / 4 - 1)) * 32'd4;
        if (r <= 13) return MEM_BYTES - 32'd4 * 32'($urandom_range(1, 6));
        if (r == 14) return 32'($urandom_range(0, 255)) * 32'd4 + 32'($urandom_range(1, 3));
        return ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC : MEM_BYTES;
    endfunction

    // Memory responder: words of an accepted request appear one per cycle,
    // starting the cycle after acceptance; garbage otherwise.
    initial begin
        int          pend;
        logic        acc;
        logic [31:0] aaddr, paddr;
        logic [1:0]  asize;
        pend = 0;
        paddr = '0;
        bus.mem_data_out = '0;
        forever begin
            @(negedge clk);
            acc   = bus.mem_enable && !bus.mem_busy;
            aaddr = bus.mem_addr;
            asize = bus.mem_access_size;
            @(posedge clk);
            #1;
            if (acc) begin
                pend  = (asize == ACCESS_BURST4) ? 4 : 1;
                paddr = aaddr;
            end
            if (pend > 0) begin
                bus.mem_data_out = mem_word(paddr);
                paddr += 32'd4;
                pend--;
            end else begin
                bus.mem_data_out = $urandom;
            end
        end
    end

    // Reference model: decode must see consecutive words from the last redirect
    // (or reset) target, and each request must start where the previous one
    // ended, with the size implied by its address.
    initial begin
        logic [31:0] exp_pc, req_pc, prev_addr;
        logic [1:0]  prev_size;
        logic        prev_redirect, prev_stall;
        exp_pc = RESET_PC;
        req_pc = RESET_PC;
        prev_addr = '0;
        prev_size = '0;
        prev_redirect = 1'b0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_pc = RESET_PC;
                req_pc = RESET_PC;
                prev_redirect = 1'b0;
                prev_stall = 1'b0;
            end else begin
                check("rd_wr", bus.mem_rd_wr, 1);
                if (bus.fetch_fault) check("fault_quiet", {bus.insn_valid, bus.mem_enable}, 0);
                if (prev_redirect) check("valid_after_redirect", bus.insn_valid, 0);
                if (prev_stall && !prev_redirect)
                    check("req_hold", {bus.mem_enable, bus.mem_access_size, bus.mem_addr},
                          {1'b1, prev_size, prev_addr});
                if (bus.mem_enable && !bus.mem_busy) begin
                    check("req_addr", bus.mem_addr, req_pc);
                    check("req_legal", (bus.mem_addr[1:0] == 2'b00) && (bus.mem_addr < MEM_BYTES), 1);
                    check("req_size", bus.mem_access_size,
                          (bus.mem_addr <= MEM_BYTES - 16) ? ACCESS_BURST4 : ACCESS_WORD);
                    req_pc = bus.mem_addr + ((bus.mem_access_size == ACCESS_BURST4) ? 32'd16 : 32'd4);
                end
                if (bus.insn_valid && bus.insn_ready && !bus.redirect) begin
                    check("xfer_pc", bus.insn_pc, exp_pc);
                    check("xfer_insn", bus.insn, mem_word(exp_pc));
                    exp_pc += 32'd4;
                    xfers++;
                end
                if (bus.redirect) begin
                    exp_pc = bus.redirect_pc;
                    req_pc = bus.redirect_pc;
                end
                prev_redirect = bus.redirect;
                prev_stall    = bus.mem_enable && bus.mem_busy;
                prev_addr     = bus.mem_addr;
                prev_size     = bus.mem_access_size;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic any_en;
        int   base;
        reset = 1'b1;
        bus.mem_busy = 1'b0;
        bus.insn_ready = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;

        // Reset values, first burst latency and refill period.
        repeat (3) tick();
        check("rst_en", bus.mem_enable, 0);
        check("rst_rd_wr", bus.mem_rd_wr, 1);
        check("rst_addr", bus.mem_addr, RESET_PC);
        check("rst_size", bus.mem_access_size, 0);
        check("rst_valid", bus.insn_valid, 0);
        check("rst_insn", bus.insn, 0);
        check("rst_pc", bus.insn_pc, 0);
        check("rst_fault", bus.fetch_fault, 0);
        reset = 1'b0;
        tick();
        check("e1_req", {bus.mem_enable, bus.mem_access_size, bus.mem_addr}, {1'b1, ACCESS_BURST4, 32'd0});
        check("e1_valid", bus.insn_valid, 0);
        tick();
        check("e2_en", bus.mem_enable, 0);
        check("e2_valid", bus.insn_valid, 0);
        tick();
        check("w0", {bus.insn_valid, bus.insn_pc, bus.insn}, {1'b1, 32'd0, 32'd234});
        tick();
        check("w1", {bus.insn_pc, bus.insn}, {32'd4, 32'd1537628013});
        tick();
        check("w2", {bus.insn_pc, bus.insn}, {32'd8, 32'd537628013});
        tick();
        check("w3", {bus.insn_pc, bus.insn}, {32'd12, 32'd2537628013});
        tick();
        check("e7_idle", {bus.insn_valid, bus.mem_enable}, 0);
        tick();
        check("e8_refill", {bus.mem_enable, bus.mem_addr}, {1'b1, 32'd16});

        // Memory busy for five cycles while a request is pending.
        bus.mem_busy = 1'b1;
        any_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!(bus.mem_enable && bus.mem_addr == 32'd16)) any_en = 1'b0;
        end
        check("busy_stable", any_en, 1);
        bus.mem_busy = 1'b0;
        tick();
        check("busy_accept", bus.mem_enable, 0);
        tick();
        check("busy_data", {bus.insn_valid, bus.insn_pc}, {1'b1, 32'd16});

        // Top of memory: single word, then out-of-range fault.
        bus.redirect = 1'b1;
        bus.redirect_pc = MEM_BYTES - 4;
        tick();
        bus.redirect = 1'b0;
        for (int i = 0; i < 20 && !bus.mem_enable; i++) tick();
        check("top_req", {bus.mem_enable, bus.mem_access_size, bus.mem_addr},
              {1'b1, ACCESS_WORD, MEM_BYTES - 32'd4});
        for (int i = 0; i < 20 && !bus.fetch_fault; i++) tick();
        check("top_fault", bus.fetch_fault, 1);
        any_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            any_en |= bus.mem_enable;
        end
        check("fault_no_req", any_en, 0);

        // Misaligned redirect faults; a good redirect clears it and resumes.
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h2;
        tick();
        bus.redirect = 1'b0;
        check("mis_clear", bus.fetch_fault, 0);
        tick();
        check("mis_fault", bus.fetch_fault, 1);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0;
        tick();
        bus.redirect = 1'b0;
        check("resume_clear", bus.fetch_fault, 0);
        for (int i = 0; i < 20 && !bus.insn_valid; i++) tick();
        check("resume_word", {bus.insn_valid, bus.insn_pc, bus.insn}, {1'b1, 32'd0, 32'd234});

        // Redirect while word 2 of a burst is on the bus.
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (4) tick();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h40;
        tick();
        bus.redirect = 1'b0;
        check("sq_valid", bus.insn_valid, 0);
        tick();
        check("sq_drain", {bus.insn_valid, bus.mem_enable}, 0);
        tick();
        check("sq_req", {bus.mem_enable, bus.mem_addr}, {1'b1, 32'h40});
        for (int i = 0; i < 10 && !bus.insn_valid; i++) tick();
        check("sq_first", {bus.insn_valid, bus.insn_pc}, {1'b1, 32'h40});

        // Decode stalls with a full queue: no new request until it drains.
        bus.insn_ready = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h80;
        tick();
        bus.redirect = 1'b0;
        for (int i = 0; i < 20 && !bus.insn_valid; i++) tick();
        repeat (4) tick();
        any_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            any_en |= bus.mem_enable;
            if (bus.insn_pc != 32'h80) any_en = 1'b1;
        end
        check("stall_hold", any_en, 0);
        base = xfers;
        bus.insn_ready = 1'b1;
        for (int i = 0; i < 20 && !bus.mem_enable; i++) tick();
        check("stall_refill", {bus.mem_enable, bus.mem_addr}, {1'b1, 32'h90});
        check("stall_drained", xfers - base, 4);

        // Randomized traffic against the model.
        base = xfers;
        for (int c = 0; c < 3000; c++) begin
            bus.mem_busy   = ($urandom_range(0, 99) < 30);
            bus.insn_ready = ($urandom_range(0, 99) < 70);
            reset          = ($urandom_range(0, 999) < 3);
            bus.redirect   = 1'b0;
            if (!reset && (($urandom_range(0, 99) < 3) ||
                           (bus.fetch_fault && $urandom_range(0, 9) == 0))) begin
                bus.redirect    = 1'b1;
                bus.redirect_pc = pick_pc();
            end
            tick();
        end
        reset = 1'b0;
        bus.redirect = 1'b0;
        repeat (3) tick();
        check("rand_progress", (xfers - base) > 200, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
